// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory port arbiter.
package mips_mem_pkg;

    localparam int AW_DEF         = 32;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating counter of consecutive data-port grants taken while a fetch was waiting.
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int            W     = $clog2(MAX + 1);
    localparam logic [W-1:0]  MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear has priority so an IF grant always restarts the fairness window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage,
// one req/ack transaction at a time, with stall outputs that freeze the pipeline.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_valid_o,
    output logic          if_stall_o,
    input  logic          dm_re_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_valid_o,
    output logic          dm_stall_o,
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic [DW-1:0] m_rdata_i,
    input  logic          m_ack_i
);

    arb_state_t    state_q;
    logic          mReq_q, mWe_q;
    logic [AW-1:0] mAddr_q;
    logic [DW-1:0] mWdata_q;
    logic [DW-1:0] ifRdata_q, dmRdata_q;
    logic          ifValid_q, dmValid_q;

    logic dmPend, dmWins, atMax, grantDm, grantIf;

    assign dmPend  = dm_re_i | dm_we_i;
    assign dmWins  = dmPend & ~atMax;
    assign grantDm = (state_q == IDLE) & dmWins;
    assign grantIf = (state_q == IDLE) & ~dmWins & if_req_i;

    arb_starve_cnt #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (grantDm & if_req_i),
        .clr_i   (grantIf),
        .at_max_o(atMax)
    );

    // Request fields are latched at grant so the memory sees them frozen while m_req is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            mReq_q    <= 1'b0;
            mWe_q     <= 1'b0;
            mAddr_q   <= '0;
            mWdata_q  <= '0;
            ifRdata_q <= '0;
            dmRdata_q <= '0;
            ifValid_q <= 1'b0;
            dmValid_q <= 1'b0;
        end else begin
            ifValid_q <= 1'b0;
            dmValid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grantDm) begin
                        state_q  <= GNT_DM;
                        mReq_q   <= 1'b1;
                        mWe_q    <= dm_we_i;
                        mAddr_q  <= dm_addr_i;
                        mWdata_q <= dm_wdata_i;
                    end else if (grantIf) begin
                        state_q <= GNT_IF;
                        mReq_q  <= 1'b1;
                        mWe_q   <= 1'b0;
                        mAddr_q <= if_addr_i;
                    end
                end
                GNT_IF: begin
                    if (m_ack_i) begin
                        ifRdata_q <= m_rdata_i;
                        ifValid_q <= 1'b1;
                        mReq_q    <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                GNT_DM: begin
                    if (m_ack_i) begin
                        if (!mWe_q) begin
                            dmRdata_q <= m_rdata_i;
                        end
                        dmValid_q <= 1'b1;
                        mReq_q    <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_req_o    = mReq_q;
    assign m_we_o     = mWe_q;
    assign m_addr_o   = mAddr_q;
    assign m_wdata_o  = mWdata_q;
    assign if_rdata_o = ifRdata_q;
    assign if_valid_o = ifValid_q;
    assign dm_rdata_o = dmRdata_q;
    assign dm_valid_o = dmValid_q;
    assign if_stall_o = if_req_i & ~ifValid_q;
    assign dm_stall_o = dmPend & ~dmValid_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (m_req_o && $past(m_req_o)) |-> ($stable(m_addr_o) && $stable(m_we_o) && $stable(m_wdata_o)));

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(if_valid_o && dm_valid_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a wait-state memory model.
module tb_mem_port_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        if_stall_o;
    logic        dm_re_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_valid_o;
    logic        dm_stall_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i = 32'h0;
    logic        m_ack_i   = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          isDm;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;

    logic [31:0] memModel [logic [31:0]];
    int          waitStates = 0;
    int          reqCycles  = 0;

    mem_port_arbiter dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .if_req_i  (if_req_i),
        .if_addr_i (if_addr_i),
        .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o),
        .if_stall_o(if_stall_o),
        .dm_re_i   (dm_re_i),
        .dm_we_i   (dm_we_i),
        .dm_addr_i (dm_addr_i),
        .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o),
        .dm_valid_o(dm_valid_o),
        .dm_stall_o(dm_stall_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_rdata_i (m_rdata_i),
        .m_ack_i   (m_ack_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 32'(actual), 32'(expected));
    endtask

    task automatic pushExp(input bit isDm, input logic [31:0] rdata, input string name);
        exp_t e;
        e.isDm  = isDm;
        e.rdata = rdata;
        e.name  = name;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic dmRe,
                                 input logic dmWe, input logic [31:0] dmAddr, input logic [31:0] dmWdata);
        @(posedge clk_i);
        #1;
        if_req_i   = ifReq;
        if_addr_i  = ifAddr;
        dm_re_i    = dmRe;
        dm_we_i    = dmWe;
        dm_addr_i  = dmAddr;
        dm_wdata_i = dmWdata;
    endtask

    // Requester side: hold the request until its valid pulse, then drop it after the next edge.
    task automatic waitValid(input bit isDm, input int maxCycles);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge clk_i);
            seen = isDm ? dm_valid_o : if_valid_o;
        end
        if (isDm) checkBit("dm_valid_seen", seen, 1'b1);
        else      checkBit("if_valid_seen", seen, 1'b1);
        @(posedge clk_i);
        #1;
        if (isDm) begin
            dm_re_i = 1'b0;
            dm_we_i = 1'b0;
        end else begin
            if_req_i = 1'b0;
        end
    endtask

    // Memory: acks after waitStates extra cycles of m_req; forgets an abandoned request on reset.
    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni || !m_req_o) begin
            reqCycles = 0;
            m_ack_i   = 1'b0;
        end else begin
            reqCycles++;
            if (reqCycles > waitStates) begin
                m_ack_i = 1'b1;
                if (m_we_o) memModel[m_addr_o] = m_wdata_o;
                else        m_rdata_i = memModel.exists(m_addr_o) ? memModel[m_addr_o] : 32'h0;
            end else begin
                m_ack_i = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (if_valid_o && dm_valid_o) begin
                checkBit("single_valid", 1'b1, 1'b0);
            end else if (if_valid_o || dm_valid_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", {30'b0, if_valid_o, dm_valid_o}, 32'h0);
                end else begin
                    monExp = expQ.pop_front();
                    checkBit({monExp.name, "_port"}, dm_valid_o, monExp.isDm);
                    checkOutput({monExp.name, "_rdata"}, monExp.isDm ? dm_rdata_o : if_rdata_o, monExp.rdata);
                end
            end
        end
    end

    initial begin
        memModel[32'h0000_0040] = 32'h2008_0005;
        memModel[32'h0000_0044] = 32'h8C08_0004;
        memModel[32'h0000_0100] = 32'h1111_2222;

        rst_ni     = 1'b0;
        if_req_i   = 1'b0;
        if_addr_i  = 32'h0;
        dm_re_i    = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = 32'h0;
        dm_wdata_i = 32'h0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        checkBit("rst_m_req", m_req_o, 1'b0);
        checkBit("rst_if_valid", if_valid_o, 1'b0);
        checkBit("rst_dm_valid", dm_valid_o, 1'b0);
        checkOutput("rst_if_rdata", if_rdata_o, 32'h0);
        checkOutput("rst_dm_rdata", dm_rdata_o, 32'h0);
        checkOutput("rst_m_addr", m_addr_o, 32'h0);
        checkBit("rst_if_stall", if_stall_o, 1'b0);
        checkBit("rst_dm_stall", dm_stall_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkBit("post_rst_m_req", m_req_o, 1'b0);

        // Zero-wait fetch, cycle by cycle
        $display("[TB] zero-wait fetch");
        waitStates = 0;
        pushExp(1'b0, 32'h2008_0005, "t2_fetch");
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        checkBit("t2_c0_stall", if_stall_o, 1'b1);
        checkBit("t2_c0_m_req", m_req_o, 1'b0);
        @(negedge clk_i);
        checkBit("t2_c1_stall", if_stall_o, 1'b1);
        checkBit("t2_c1_m_req", m_req_o, 1'b1);
        checkOutput("t2_c1_m_addr", m_addr_o, 32'h0000_0040);
        checkBit("t2_c1_m_we", m_we_o, 1'b0);
        @(negedge clk_i);
        checkBit("t2_c2_valid", if_valid_o, 1'b1);
        checkBit("t2_c2_stall", if_stall_o, 1'b0);
        checkOutput("t2_c2_rdata", if_rdata_o, 32'h2008_0005);
        @(posedge clk_i);
        #1;
        if_req_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Simultaneous requests: data side goes first
        $display("[TB] simultaneous requests");
        pushExp(1'b1, 32'h1111_2222, "t3_dm");
        pushExp(1'b0, 32'h2008_0005, "t3_if");
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        fork
            waitValid(1'b1, 20);
            waitValid(1'b0, 40);
        join
        repeat (2) @(posedge clk_i);

        // Write with wait states; request fields must stay frozen
        $display("[TB] write with wait states");
        waitStates = 2;
        pushExp(1'b1, 32'h1111_2222, "t4_write");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
        @(negedge clk_i);
        checkBit("t4_c0_dm_stall", dm_stall_o, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            checkBit("t4_m_req", m_req_o, 1'b1);
            checkBit("t4_m_we", m_we_o, 1'b1);
            checkOutput("t4_m_addr", m_addr_o, 32'h0000_0200);
            checkOutput("t4_m_wdata", m_wdata_o, 32'hDEAD_BEEF);
            if (c == 1) begin
                dm_addr_i  = 32'h0000_0300;
                dm_wdata_i = 32'h0;
            end
        end
        @(negedge clk_i);
        checkBit("t4_valid", dm_valid_o, 1'b1);
        checkBit("t4_m_req_low", m_req_o, 1'b0);
        @(posedge clk_i);
        #1;
        dm_we_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Starvation: continuous data reads with a pending fetch
        $display("[TB] starvation limit");
        waitStates = 0;
        for (int k = 0; k < 4; k++) pushExp(1'b1, 32'h1111_2222, "t5_dm");
        pushExp(1'b0, 32'h2008_0005, "t5_if");
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        waitValid(1'b0, 60);
        dm_re_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Counter cleared: data wins again, and reads back the earlier write
        pushExp(1'b1, 32'hDEAD_BEEF, "t5_after_dm");
        pushExp(1'b0, 32'h8C08_0004, "t5_after_if");
        applyStimulus(1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        fork
            waitValid(1'b1, 20);
            waitValid(1'b0, 40);
        join
        repeat (2) @(posedge clk_i);

        // Reset in the middle of a stalled data access
        $display("[TB] reset mid-transaction");
        waitStates = 50;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        checkBit("t6_m_req_before", m_req_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkBit("t6_m_req_drop", m_req_o, 1'b0);
        checkBit("t6_dm_valid", dm_valid_o, 1'b0);
        checkOutput("t6_dm_rdata", dm_rdata_o, 32'h0);
        checkOutput("t6_if_rdata", if_rdata_o, 32'h0);
        checkOutput("t6_m_addr", m_addr_o, 32'h0);
        dm_re_i = 1'b0;
        waitStates = 0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checkBit("t6_idle_m_req", m_req_o, 1'b0);
        pushExp(1'b1, 32'hDEAD_BEEF, "t6_fresh");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        waitValid(1'b1, 20);
        repeat (3) @(posedge clk_i);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
